// File: rtl/st_pkt_serializer.sv
// Width down-converter for the ready/valid packet stream: one wide word in,
// RATIO (or fewer, on a short eop word) little-endian narrow beats out.
module st_pkt_serializer #(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sop,
    input  logic                           in_eop,
    input  logic [IN_WIDTH-1:0]            in_data,
    input  logic [$clog2(IN_WIDTH/8)-1:0]  in_len,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic [$clog2(OUT_WIDTH/8)-1:0] out_len
);

    localparam int unsigned RATIO     = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned IN_BYTES  = IN_WIDTH / 8;
    localparam int unsigned OUT_BYTES = OUT_WIDTH / 8;
    localparam int unsigned IDX_W     = $clog2(RATIO);
    localparam int unsigned OLEN_W    = $clog2(OUT_BYTES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_d;
    logic [IN_WIDTH-1:0] shreg, shreg_d;
    logic [IDX_W-1:0]    idx, idx_d, idx_inc;
    logic [IDX_W-1:0]    last_idx, last_idx_d, cap_last;
    logic                eop_cap, eop_cap_d;
    logic [OLEN_W-1:0]   len_cap, len_cap_d, cap_rem, out_len_d;
    logic                out_valid_d, out_sop_d, out_eop_d;
    logic                last_beat, in_fire;
    int unsigned         nb;

    assign last_beat = (idx == last_idx);
    assign in_ready  = !rst && ((state == IDLE) || ((state == SEND) && out_ready && last_beat));
    assign in_fire   = in_valid && in_ready;
    assign idx_inc   = idx + IDX_W'(1);
    // The current beat always sits in the low lane of the shifting holding register.
    assign out_data  = shreg[OUT_WIDTH-1:0];

    // Byte count and final beat index of the word being offered.
    always_comb begin
        nb = IN_BYTES;
        if (in_eop && (in_len != '0)) begin
            nb = 32'(in_len);
        end
        cap_last = IDX_W'((nb + OUT_BYTES - 1) / OUT_BYTES - 1);
        cap_rem  = OLEN_W'(nb % OUT_BYTES);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        shreg_d     = shreg;
        idx_d       = idx;
        last_idx_d  = last_idx;
        eop_cap_d   = eop_cap;
        len_cap_d   = len_cap;
        out_valid_d = out_valid;
        out_sop_d   = out_sop;
        out_eop_d   = out_eop;
        out_len_d   = out_len;

        case (state)
            IDLE: state_d = IDLE;
            SEND: begin
                if (out_ready) begin
                    if (!last_beat) begin
                        shreg_d   = shreg >> OUT_WIDTH;
                        idx_d     = idx_inc;
                        out_sop_d = 1'b0;
                        out_eop_d = eop_cap && (idx_inc == last_idx);
                        out_len_d = (eop_cap && (idx_inc == last_idx)) ? len_cap : '0;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_sop_d   = 1'b0;
                        out_eop_d   = 1'b0;
                        out_len_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture only happens from IDLE or on a completing last beat, so it wins.
        if (in_fire) begin
            state_d     = SEND;
            shreg_d     = in_data;
            idx_d       = '0;
            last_idx_d  = cap_last;
            eop_cap_d   = in_eop;
            len_cap_d   = cap_rem;
            out_valid_d = 1'b1;
            out_sop_d   = in_sop;
            out_eop_d   = in_eop && (cap_last == '0);
            out_len_d   = (in_eop && (cap_last == '0)) ? cap_rem : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            last_idx  <= '0;
            eop_cap   <= 1'b0;
            len_cap   <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_len   <= '0;
        end else begin
            state     <= state_d;
            shreg     <= shreg_d;
            idx       <= idx_d;
            last_idx  <= last_idx_d;
            eop_cap   <= eop_cap_d;
            len_cap   <= len_cap_d;
            out_valid <= out_valid_d;
            out_sop   <= out_sop_d;
            out_eop   <= out_eop_d;
            out_len   <= out_len_d;
        end
    end

endmodule

// File: tb/tb_st_pkt_serializer.sv
// Self-checking bench for st_pkt_serializer (64 -> 16): directed framing cases,
// back-to-back packets, backpressure, mid-word reset and randomized traffic.
module tb_st_pkt_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [63:0] in_data = '0;
    logic [2:0]  in_len = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] out_data;
    logic        out_len;

    st_pkt_serializer #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .out_len(out_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        logic        len;
        logic        inr;   // observed: in_ready at the beat; expected: last beat of its word
        int          cyc;
    } beat_t;

    beat_t obs[$];
    beat_t exp[$];
    beat_t mb;
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    hold_viol = 0;
    int    stall_inr = 0;
    int    stall_cnt = 0;
    int    rdy_mode = 0;
    int    pcnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] p_data;
    logic        p_sop, p_eop, p_len;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready pattern generator: 0 = always ready, 1 = random, 2 = 1,0,0 repeating
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin out_ready = ((pcnt % 3) == 0); pcnt++; end
            default: out_ready = 1'b1;
        endcase
    end

    // Mid-cycle monitor: records delivered beats and stall behaviour.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                mb.data = out_data; mb.sop = out_sop; mb.eop = out_eop;
                mb.len = out_len; mb.inr = in_ready; mb.cyc = cyc;
                obs.push_back(mb);
            end
            if (in_valid && in_ready) acc_cyc = cyc;
            if (out_valid && !out_ready) begin
                stall_cnt++;
                if (in_ready) stall_inr++;
            end
            if (prev_stall && (!out_valid || out_data !== p_data || out_sop !== p_sop ||
                               out_eop !== p_eop || out_len !== p_len)) hold_viol++;
            prev_stall = out_valid && !out_ready;
            p_data = out_data; p_sop = out_sop; p_eop = out_eop; p_len = out_len;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference model: expected beat list of one accepted word.
    function automatic void model_word(input logic [63:0] d, input logic s, input logic e,
                                       input logic [2:0] l);
        int    nb;
        int    nbeats;
        beat_t b;
        nb     = (e && l != 3'd0) ? int'(l) : 8;
        nbeats = (nb + 1) / 2;
        for (int k = 0; k < nbeats; k++) begin
            b.data = 16'(d >> (16 * k));
            b.sop  = s && (k == 0);
            b.eop  = e && (k == nbeats - 1);
            b.len  = b.eop ? 1'(nb % 2) : 1'b0;
            b.inr  = (k == nbeats - 1);
            b.cyc  = 0;
            exp.push_back(b);
        end
    endfunction

    task automatic drive_word(input logic [63:0] d, input logic s, input logic e,
                              input logic [2:0] l);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_len = l;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_len = '0; in_data = '0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept_timeout: accepted=0 required=1");
        end else begin
            model_word(d, s, e, l);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (obs.size() < exp.size() && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_sop, out_eop, out_len} !== 4'b0 || out_data !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b s=%b e=%b l=%b d=%h want all 0",
                     out_valid, out_sop, out_eop, out_len, out_data);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_single_word();
        int lens[3];
        int cnt[3];
        lens = '{0, 5, 2};
        cnt  = '{4, 3, 1};
        rdy_mode = 0;
        for (int t = 0; t < 3; t++) begin
            obs.delete();
            exp.delete();
            drive_word(64'h4444_3333_2222_1111, 1'b1, 1'b1, 3'(lens[t]));
            drain();
            n_cmp++;
            if (obs.size() != cnt[t] || exp.size() != cnt[t]) begin
                n_err++;
                $display("FAIL single_len%0d_count: got %0d beats want %0d", lens[t], obs.size(), cnt[t]);
            end
            for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
                n_cmp++;
                if (obs[i].data !== exp[i].data || obs[i].sop !== exp[i].sop ||
                    obs[i].eop !== exp[i].eop || obs[i].len !== exp[i].len ||
                    obs[i].cyc != acc_cyc + 1 + i) begin
                    n_err++;
                    $display("FAIL single_len%0d_beat%0d: got d=%h s=%b e=%b l=%b cyc=%0d want d=%h s=%b e=%b l=%b cyc=%0d",
                             lens[t], i, obs[i].data, obs[i].sop, obs[i].eop, obs[i].len, obs[i].cyc,
                             exp[i].data, exp[i].sop, exp[i].eop, exp[i].len, acc_cyc + 1 + i);
                end
            end
            if (lens[t] == 2 && obs.size() > 0) begin
                n_cmp++;
                if (obs[0].inr !== 1'b1) begin
                    n_err++;
                    $display("FAIL single_len2_in_ready: got %b want 1", obs[0].inr);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rdy_mode = 0;
        obs.delete();
        exp.delete();
        for (int p = 0; p < 2; p++) begin
            drive_word({$urandom(), $urandom()}, 1'b1, 1'b0, 3'd0);
            drive_word({$urandom(), $urandom()}, 1'b0, 1'b1, 3'd0);
        end
        drain();
        n_cmp++;
        if (obs.size() != 16) begin
            n_err++;
            $display("FAIL b2b_count: got %0d beats want 16", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
            n_cmp++;
            if (obs[i].data !== exp[i].data || obs[i].sop !== exp[i].sop ||
                obs[i].eop !== exp[i].eop || obs[i].len !== exp[i].len ||
                obs[i].inr !== exp[i].inr || obs[i].cyc != obs[0].cyc + i) begin
                n_err++;
                $display("FAIL b2b_beat%0d: got d=%h s=%b e=%b l=%b rdy=%b cyc=%0d want d=%h s=%b e=%b l=%b rdy=%b cyc=%0d",
                         i, obs[i].data, obs[i].sop, obs[i].eop, obs[i].len, obs[i].inr, obs[i].cyc,
                         exp[i].data, exp[i].sop, exp[i].eop, exp[i].len, exp[i].inr, obs[0].cyc + i);
            end
        end
    endtask

    task automatic test_backpressure();
        obs.delete();
        exp.delete();
        hold_viol = 0;
        stall_inr = 0;
        stall_cnt = 0;
        pcnt = 0;
        rdy_mode = 2;
        drive_word({$urandom(), $urandom()}, 1'b1, 1'b1, 3'd0);
        drain();
        rdy_mode = 0;
        n_cmp++;
        if (obs.size() != 4) begin
            n_err++;
            $display("FAIL bp_count: got %0d beats want 4", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
            n_cmp++;
            if (obs[i].data !== exp[i].data || obs[i].sop !== exp[i].sop ||
                obs[i].eop !== exp[i].eop || obs[i].len !== exp[i].len || obs[i].inr !== exp[i].inr) begin
                n_err++;
                $display("FAIL bp_beat%0d: got d=%h s=%b e=%b l=%b rdy=%b want d=%h s=%b e=%b l=%b rdy=%b",
                         i, obs[i].data, obs[i].sop, obs[i].eop, obs[i].len, obs[i].inr,
                         exp[i].data, exp[i].sop, exp[i].eop, exp[i].len, exp[i].inr);
            end
        end
        n_cmp++;
        if (hold_viol != 0 || stall_inr != 0 || stall_cnt == 0) begin
            n_err++;
            $display("FAIL bp_hold: got hold_viol=%0d stall_in_ready=%0d stalls=%0d want 0 0 >0",
                     hold_viol, stall_inr, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_word();
        beat_t keep;
        rdy_mode = 0;
        obs.delete();
        exp.delete();
        drive_word(64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 1'b1, 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_sop, out_eop, out_len} !== 4'b0 || out_data !== 16'h0) begin
            n_err++;
            $display("FAIL midreset_outputs: got v=%b s=%b e=%b l=%b d=%h want all 0",
                     out_valid, out_sop, out_eop, out_len, out_data);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_in_ready: got %b want 1", in_ready);
        end
        // Only beat 0 was delivered before the reset; the rest of the word is discarded.
        keep = exp[0];
        exp.delete();
        exp.push_back(keep);
        @(posedge clk);
        #1;
        drive_word(64'h8888_7777_6666_5555, 1'b1, 1'b1, 3'd0);
        drain();
        n_cmp++;
        if (obs.size() != 5) begin
            n_err++;
            $display("FAIL midreset_count: got %0d beats want 5", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
            n_cmp++;
            if (obs[i].data !== exp[i].data || obs[i].sop !== exp[i].sop ||
                obs[i].eop !== exp[i].eop || obs[i].len !== exp[i].len) begin
                n_err++;
                $display("FAIL midreset_beat%0d: got d=%h s=%b e=%b l=%b want d=%h s=%b e=%b l=%b",
                         i, obs[i].data, obs[i].sop, obs[i].eop, obs[i].len,
                         exp[i].data, exp[i].sop, exp[i].eop, exp[i].len);
            end
        end
    endtask

    task automatic test_random();
        int g;
        obs.delete();
        exp.delete();
        hold_viol = 0;
        rdy_mode = 1;
        for (int w = 0; w < 40; w++) begin
            drive_word({$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            g = $urandom_range(0, 2);
            repeat (g) begin @(posedge clk); #1; end
        end
        drain();
        rdy_mode = 0;
        n_cmp++;
        if (obs.size() != exp.size()) begin
            n_err++;
            $display("FAIL rand_count: got %0d beats want %0d", obs.size(), exp.size());
        end
        for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
            n_cmp++;
            if (obs[i].data !== exp[i].data || obs[i].sop !== exp[i].sop ||
                obs[i].eop !== exp[i].eop || obs[i].len !== exp[i].len) begin
                n_err++;
                $display("FAIL rand_beat%0d: got d=%h s=%b e=%b l=%b want d=%h s=%b e=%b l=%b",
                         i, obs[i].data, obs[i].sop, obs[i].eop, obs[i].len,
                         exp[i].data, exp[i].sop, exp[i].eop, exp[i].len);
            end
        end
        n_cmp++;
        if (hold_viol != 0) begin
            n_err++;
            $display("FAIL rand_hold: got hold_viol=%0d want 0", hold_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
